// File: rtl/gptp_tx_serializer_if.sv
// Send request/response channel between the gPTP TX message buffer and the serializer.
interface gptp_tx_serializer_if;
    logic [7:0]  send_addr;
    logic        send_vaild;
    logic        send_ready;
    logic [79:0] send_data;
    logic        send_r_vaild;
    logic [79:0] send_r_data;

    modport master (
        output send_addr, send_vaild, send_data,
        input  send_ready, send_r_vaild, send_r_data
    );

    modport slave (
        input  send_addr, send_vaild, send_data,
        output send_ready, send_r_vaild, send_r_data
    );
endinterface

// File: rtl/gptp_tx_serializer.sv
// Frames one 80-bit message as preamble/SFD/type/payload bytes and returns
// the RTC value sampled at the SFD byte as the egress timestamp.
module gptp_tx_serializer #(
    parameter int unsigned PREAMBLE_BYTES = 7,
    parameter int unsigned IFG_CYCLES     = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    gptp_tx_serializer_if.slave         send,
    input  logic [79:0]                 rtc_time,
    output logic [7:0]                  tx_data,
    output logic                        tx_en,
    output logic                        addr_err
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, TYPE, DATA, IFG, ERR} state_t;

    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_BYTES - 1);
    localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

    state_t      state;
    logic [3:0]  byte_cnt;
    logic [7:0]  ifg_cnt;
    logic [2:0]  slot_q;
    logic [79:0] data_q;
    logic [79:0] cap_q;

    logic [2:0]  slot_enc;
    logic        addr_onehot;

    always_comb begin
        slot_enc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (send.send_addr[i]) slot_enc = 3'(i);
        end
        addr_onehot = (send.send_addr != 8'h00) &&
                      ((send.send_addr & (send.send_addr - 8'd1)) == 8'h00);
    end

    assign send.send_ready = (state == IDLE) & ~reset;

    // Outputs are loaded with the value for the state being entered, so each
    // byte appears in the cycle the state occupies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            byte_cnt          <= '0;
            ifg_cnt           <= '0;
            slot_q            <= '0;
            data_q            <= '0;
            cap_q             <= '0;
            tx_data           <= '0;
            tx_en             <= 1'b0;
            addr_err          <= 1'b0;
            send.send_r_vaild <= 1'b0;
            send.send_r_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (send.send_vaild) begin
                        slot_q   <= slot_enc;
                        data_q   <= send.send_data;
                        byte_cnt <= '0;
                        if (addr_onehot) begin
                            state   <= PRE;
                            tx_en   <= 1'b1;
                            tx_data <= 8'h55;
                        end else begin
                            state             <= ERR;
                            addr_err          <= 1'b1;
                            send.send_r_vaild <= 1'b1;
                            send.send_r_data  <= '0;
                        end
                    end
                end
                PRE: begin
                    if (byte_cnt == PRE_LAST) begin
                        state   <= SFD;
                        tx_data <= 8'hD5;
                    end else begin
                        byte_cnt <= byte_cnt + 4'd1;
                    end
                end
                SFD: begin
                    cap_q   <= rtc_time;
                    state   <= TYPE;
                    tx_data <= {5'b0, slot_q};
                end
                TYPE: begin
                    state    <= DATA;
                    byte_cnt <= '0;
                    tx_data  <= data_q[79:72];
                    data_q   <= {data_q[71:0], 8'h00};
                end
                DATA: begin
                    if (byte_cnt == 4'd9) begin
                        state             <= IFG;
                        tx_en             <= 1'b0;
                        tx_data           <= '0;
                        ifg_cnt           <= '0;
                        send.send_r_vaild <= 1'b1;
                        send.send_r_data  <= cap_q;
                    end else begin
                        byte_cnt <= byte_cnt + 4'd1;
                        tx_data  <= data_q[79:72];
                        data_q   <= {data_q[71:0], 8'h00};
                    end
                end
                IFG: begin
                    send.send_r_vaild <= 1'b0;
                    if (ifg_cnt == IFG_LAST) begin
                        state   <= IDLE;
                        ifg_cnt <= '0;
                    end else begin
                        ifg_cnt <= ifg_cnt + 8'd1;
                    end
                end
                ERR: begin
                    send.send_r_vaild <= 1'b0;
                    ifg_cnt           <= '0;
                    state             <= IFG;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/gptp_tx_serializer.md
# gptp_tx_serializer

Transmit-side framer downstream of the gPTP TX message buffer. Accepts one 80-bit message per handshake with a one-hot slot address, serializes it onto an 8-bit transmit byte stream (preamble, SFD, type byte, 10 payload bytes), and captures the local RTC at the SFD byte. Returns the captured value as the egress timestamp on the response channel.

## Interface
Parameters:
- PREAMBLE_BYTES, 7: number of 8'h55 bytes before the SFD; legal range 1..15.
- IFG_CYCLES, 12: idle cycles after the last payload byte before the next accept; legal range 3..255.

Ports:
- clk  input  1  clock; single clock domain.
- reset  input  1  reset; one clock, asynchronous, active-high.
- send_addr  input  8  one-hot message slot; valid only while send_vaild=1.
- send_vaild  input  1  request valid; upstream holds it, with addr and data stable, until it sees send_r_vaild.
- send_ready  output  1  block can accept; equals (state==IDLE) & ~reset.
- send_data  input  80  message payload; bits [79:72] are transmitted first.
- send_r_vaild  output  1  one-cycle pulse: egress timestamp available.
- send_r_data  output  80  captured timestamp; holds until the next capture.
- rtc_time  input  80  free-running local time: {48-bit seconds, 32-bit ns}.
- tx_data  output  8  transmit byte.
- tx_en  output  1  tx_data is valid this cycle.
- addr_err  output  1  sticky flag; set by a non-one-hot send_addr and cleared only by reset.

## Operation
- Transfer occurs on a rising clk edge with send_vaild & send_ready. That edge latches send_addr, send_data and the slot index into internal registers. The 3-bit slot index is the encoded position of the one-hot bit.
- States: IDLE, PRE, SFD, TYPE, DATA, IFG, ERR. A 4-bit byte counter and an 8-bit IFG counter sequence the states.
- IDLE: on transfer, go to PRE if send_addr is one-hot, otherwise go to ERR.
- PRE: tx_en=1, tx_data=8'h55 for PREAMBLE_BYTES cycles, then go to SFD.
- SFD: tx_en=1, tx_data=8'hD5. rtc_time is registered into an internal capture register at the edge ending this cycle. Next state is TYPE.
- TYPE: tx_en=1, tx_data={5'b0, slot index}. Next state is DATA.
- DATA: tx_en=1. Sends 10 bytes, latched data[79:72] down to [7:0]. Next state is IFG.
- IFG: tx_en=0, tx_data=0. In the first IFG cycle, send_r_vaild=1 and send_r_data=the captured value. Stay IFG_CYCLES cycles total, then go to IDLE.
- ERR: addr_err is set, send_r_vaild=1 for one cycle with send_r_data=80'h0, no bytes are transmitted, then go to IFG. In this path send_r_vaild is not repeated in IFG.
- Response re-acceptance is prevented because IFG_CYCLES≥3 keeps send_ready=0 until upstream has dropped send_vaild.
- Outside PRE/SFD/TYPE/DATA: tx_en=0 and tx_data=8'h00.

## Timing
- Reset values (asynchronous, while reset=1): state IDLE, send_ready 0, send_r_vaild 0, send_r_data 0, tx_en 0, tx_data 0, addr_err 0, all counters 0.
- All outputs are registered except send_ready.
- With transfer at edge 0, P=PREAMBLE_BYTES and I=IFG_CYCLES:
  - Preamble occupies cycles 1..P.
  - SFD is cycle P+1, and rtc_time is sampled at the end of it.
  - TYPE is cycle P+2.
  - DATA occupies cycles P+3..P+12.
  - send_r_vaild is high in cycle P+13.
  - send_ready returns high in cycle P+13+I.
- Defaults (P=7, I=12): SFD in cycle 8, send_r_vaild in cycle 20, next accept possible in cycle 32. Frame length is P+12 bytes.
- Error path: send_r_vaild is high in cycle 1, and send_ready returns in cycle 2+I.
- Reset mid-frame: tx_en falls asynchronously, the frame is truncated, no send_r_vaild is produced, and send_r_data is cleared.
- send_vaild deasserted after transfer has no effect; the frame completes from latched values.
- rtc_time wrap (ns rollover) is not interpreted; the capture is a raw 80-bit sample.

## Test plan
- Single frame: addr=8'h04, data=80'h0102_0304_0506_0708_090A, rtc_time=cycle count -> tx_en cycles 1..19 carry 55×7, D5, 02, then 01..0A; send_r_vaild in cycle 20 with send_r_data equal to the rtc value of cycle 8.
- Held valid: upstream keeps send_vaild high until 2 cycles after send_r_vaild -> exactly one frame; send_ready=0 until cycle 32.
- Back-to-back: second request (addr=8'h80) pending at cycle 32 -> accepted at cycle 32; TYPE byte 8'h07; timestamp from cycle 40.
- Bad address: addr=8'h03 and separately 8'h00 -> no tx_en, send_r_vaild in cycle 1 with data 0, addr_err stays 1 until reset.
- Reset mid-DATA: assert reset in cycle 14 -> tx_en 0 immediately, no send_r_vaild, send_r_data 0; after release a new frame works normally.
- Parameter sweep: PREAMBLE_BYTES=1 with IFG_CYCLES=3 -> SFD in cycle 2, send_r_vaild in cycle 14, send_ready in cycle 17.
